monitor_cmd_sequencer: RTL

Command sequencer for the monitor UART link: runs the command protocol on top of the existing `uart_rx`/`uart_tx` byte interfaces. It owns RTS/CTS flow control, captures the command byte and the data-size byte, then either streams received bytes into the monitor register bank (write) or streams register-bank bytes out through the transmitter (read). It sits between the UART byte engines and the register bank in the monitor top.

---
 rtl/monitor_cmd_sequencer_if.sv | 29 ++
 rtl/monitor_cmd_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/monitor_cmd_sequencer_if.sv
// Byte-level connections between the command sequencer, the UART engines and the register bank.
interface monitor_cmd_sequencer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_byte;
    logic              rx_error;
    logic              uart_rts;
    logic              uart_cts;
    logic              tx_write;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_ready;
    logic [6:0]        reg_addr;
    logic [7:0]        reg_index;
    logic              reg_wr_en;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_rd_en;
    logic [DATA_W-1:0] reg_rdata;

    modport master (
        input  rx_valid, rx_byte, rx_error, uart_rts, tx_ready, reg_rdata,
        output uart_cts, tx_write, tx_byte, reg_addr, reg_index, reg_wr_en, reg_wdata, reg_rd_en
    );

    modport slave (
        output rx_valid, rx_byte, rx_error, uart_rts, tx_ready, reg_rdata,
        input  uart_cts, tx_write, tx_byte, reg_addr, reg_index, reg_wr_en, reg_wdata, reg_rd_en
    );
endinterface

// File: rtl/monitor_cmd_sequencer.sv
// Monitor UART command sequencer: RTS/CTS handshake, command/size capture, then
// streams rx bytes into the register bank (write) or register bytes out to tx (read).
module monitor_cmd_sequencer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    monitor_cmd_sequencer_if.master bus,
    output logic [2:0]              state,
    output logic [7:0]              cmd,
    output logic [7:0]              data_size,
    output logic                    cmd_done,
    output logic                    error
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_SIZE     = 3'd2,
        S_WRITE    = 3'd3,
        S_RD_FETCH = 3'd4,
        S_RD_WAIT  = 3'd5,
        S_RD_SEND  = 3'd6,
        S_DONE     = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        size_q, size_d;
    logic [7:0]        idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic              tx_write_q, tx_write_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              cts_q, cts_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            size_q     <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            tx_byte_q  <= '0;
            tx_write_q <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            cts_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            size_q     <= size_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            tx_byte_q  <= tx_byte_d;
            tx_write_q <= tx_write_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            cts_q      <= cts_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        size_d     = size_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        tx_byte_d  = tx_byte_q;
        tx_write_d = tx_write_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!bus.uart_rts) state_d = S_CMD;
            end
            S_CMD: begin
                if (bus.rx_error) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bus.rx_valid) begin
                    cmd_d   = 8'(bus.rx_byte);
                    state_d = S_SIZE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_SIZE: begin
                if (bus.rx_error) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bus.rx_valid) begin
                    size_d = 8'(bus.rx_byte);
                    idx_d  = '0;
                    if (bus.rx_byte == '0) begin
                        state_d = S_DONE;
                    end else if (cmd_q[7]) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD_FETCH;
                        rd_en_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_WRITE: begin
                // Index advances the cycle after a strobe so it stays aligned with the strobe it labels.
                if (wr_en_q) idx_d = idx_q + 8'd1;
                if (bus.rx_error) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (bus.rx_valid) begin
                    wr_en_d = 1'b1;
                    wdata_d = bus.rx_byte;
                    if (idx_d == size_q - 8'd1) state_d = S_DONE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_RD_FETCH: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_byte_d  = bus.reg_rdata;
                tx_write_d = 1'b1;
                state_d    = S_RD_SEND;
            end
            S_RD_SEND: begin
                if (bus.tx_ready) begin
                    tx_write_d = 1'b0;
                    if (idx_q == size_q - 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        rd_en_d = 1'b1;
                        state_d = S_RD_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // CTS, done pulse and timeout counter all follow the state being entered.
        done_d = (state_d == S_DONE);
        cts_d  = !(state_d inside {S_CMD, S_SIZE, S_WRITE});
        if (!(state_q inside {S_CMD, S_SIZE, S_WRITE}) || bus.rx_valid || (state_d != state_q))
            cnt_d = '0;
        else
            cnt_d = cnt_q + CNT_W'(1);
    end

    assign bus.uart_cts  = cts_q;
    assign bus.tx_write  = tx_write_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.reg_addr  = cmd_q[6:0];
    assign bus.reg_index = idx_q;
    assign bus.reg_wr_en = wr_en_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_rd_en = rd_en_q;
    assign state         = state_q;
    assign cmd           = cmd_q;
    assign data_size     = size_q;
    assign cmd_done      = done_q;
    assign error         = err_q;
endmodule
